// File: rtl/gpi_input_conditioner.sv
// gpi_input_conditioner
// ---------------------
// Per-pin conditioner for raw, asynchronous pad levels. Each pin is
// synchronized into the PCLK domain and then either debounced or passed
// straight through, which produces the clean `gpi` vector.
//
// Optional feature macro: GPI_COND_EDGE_IRQ_EN
//   defined   : rise/fall edge pulses, sticky per-pin evt_status with
//               evt_clr, and a maskable level interrupt are built.
//   undefined : rise_evt, fall_evt, evt_status and irq are tied low, and
//               evt_clr and irq_mask are ignored. Synchronizer and debounce
//               behave exactly the same in both builds.
//
// Interface timing:
//   There is no handshake. Every output is a registered level or a
//   one-cycle pulse, except irq, which is combinational from evt_status
//   and irq_mask. Inputs are sampled on every rising edge of PCLK.
//   PRESET is asynchronous and active-low.

module gpi_input_conditioner #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 16
) (
    input  logic             PCLK,
    input  logic             PRESET,
    input  logic [WIDTH-1:0] pad_in,
    input  logic [WIDTH-1:0] db_en,
    output logic [WIDTH-1:0] gpi,
    output logic [WIDTH-1:0] rise_evt,
    output logic [WIDTH-1:0] fall_evt,
    output logic [WIDTH-1:0] evt_status,
    input  logic [WIDTH-1:0] evt_clr,
    input  logic [WIDTH-1:0] irq_mask,
    output logic             irq
);

    // One extra bit keeps the counter width non-zero when DB_CYCLES is 1.
    localparam int CW = $clog2(DB_CYCLES) + 1;
    // Terminal count: when it is reached, the new level is accepted.
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    // ------------------------------------------------------------------
    // Synchronizer
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] s;

    // Shift the raw pad levels through the synchronizer chain.
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= pad_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Debounce / bypass
    // ------------------------------------------------------------------
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];
    logic [WIDTH-1:0] gpi_d;

    // Next gpi level and counter value for each pin.
    // A pin in bypass follows s directly, and its counter is forced to 0.
    // Because the counter is forced to 0, changing db_en in the middle of a
    // count never carries a partial count over.
    // A debounced pin accepts s only after s has differed from gpi for
    // DB_CYCLES consecutive edges. If s agrees with gpi again at any point,
    // the count restarts.
    always_comb begin
        gpi_d = gpi;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (!db_en[i]) begin
                gpi_d[i] = s[i];
            end else if (s[i] != gpi[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    gpi_d[i] = s[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    // Register the conditioned levels and the per-pin counters.
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            gpi <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            gpi <= gpi_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Edge detect, sticky status, interrupt
    // ------------------------------------------------------------------
`ifdef GPI_COND_EDGE_IRQ_EN
    logic [WIDTH-1:0] rise_d;
    logic [WIDTH-1:0] fall_d;

    // Edges are computed from the next gpi value. The pulses therefore
    // register on the same edge as the gpi change itself.
    always_comb begin
        rise_d = gpi_d & ~gpi;
        fall_d = gpi & ~gpi_d;
    end

    // Register the edge pulses and update the sticky status.
    // When a new event and a clear arrive in the same cycle, the event wins.
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            rise_evt   <= '0;
            fall_evt   <= '0;
            evt_status <= '0;
        end else begin
            rise_evt   <= rise_d;
            fall_evt   <= fall_d;
            evt_status <= (evt_status & ~evt_clr) | rise_d | fall_d;
        end
    end

    assign irq = |(evt_status & irq_mask);
`else
    // The event controls have no function in this build.
    logic unused_evt_inputs;
    assign unused_evt_inputs = ^{evt_clr, irq_mask};

    assign rise_evt   = '0;
    assign fall_evt   = '0;
    assign evt_status = '0;
    assign irq        = 1'b0;
`endif

endmodule

// File: tb/tb_gpi_input_conditioner.sv
// Testbench for gpi_input_conditioner (WIDTH=8, SYNC_STAGES=2, DB_CYCLES=4).
// The driver applies directed inputs and pushes the hand-computed output
// state expected after each edge. A negedge monitor pops and compares those
// entries. When GPI_COND_EDGE_IRQ_EN is undefined, the event-side
// expectations collapse to zero.

module tb_gpi_input_conditioner;

    localparam int W  = 8;
    localparam int EW = 4 * W + 1;

    logic         PCLK;
    logic         PRESET;
    logic [W-1:0] pad_in;
    logic [W-1:0] db_en;
    logic [W-1:0] gpi;
    logic [W-1:0] rise_evt;
    logic [W-1:0] fall_evt;
    logic [W-1:0] evt_status;
    logic [W-1:0] evt_clr;
    logic [W-1:0] irq_mask;
    logic         irq;

    gpi_input_conditioner #(
        .WIDTH       (W),
        .SYNC_STAGES (2),
        .DB_CYCLES   (4)
    ) dut (
        .PCLK       (PCLK),
        .PRESET     (PRESET),
        .pad_in     (pad_in),
        .db_en      (db_en),
        .gpi        (gpi),
        .rise_evt   (rise_evt),
        .fall_evt   (fall_evt),
        .evt_status (evt_status),
        .evt_clr    (evt_clr),
        .irq_mask   (irq_mask),
        .irq        (irq)
    );

    // ---------------- clock / reset ----------------
    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q [$];
    string         name_q [$];
    int            checks   = 0;
    int            failures = 0;

    logic [W-1:0] e_gpi, e_rise, e_fall, e_st;

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", n, act, req);
        end
    endtask

    function automatic logic model_irq();
`ifdef GPI_COND_EDGE_IRQ_EN
        return |(e_st & irq_mask);
`else
        return 1'b0;
`endif
    endfunction

    function automatic void push_exp(input string n);
        logic [W-1:0] r, f, st;
`ifdef GPI_COND_EDGE_IRQ_EN
        r = e_rise; f = e_fall; st = e_st;
`else
        r = '0; f = '0; st = '0;
`endif
        exp_q.push_back({e_gpi, r, f, st, model_irq()});
        name_q.push_back(n);
    endfunction

    // Monitor: compare the DUT outputs against the oldest expectation.
    logic [EW-1:0] cur;
    string         cur_name;
    always @(negedge PCLK) begin
        if (exp_q.size() > 0) begin
            cur      = exp_q.pop_front();
            cur_name = name_q.pop_front();
            check({cur_name, ".gpi"},    32'(gpi),        32'(cur[32:25]));
            check({cur_name, ".rise"},   32'(rise_evt),   32'(cur[24:17]));
            check({cur_name, ".fall"},   32'(fall_evt),   32'(cur[16:9]));
            check({cur_name, ".status"}, 32'(evt_status), 32'(cur[8:1]));
            check({cur_name, ".irq"},    32'(irq),        32'(cur[0]));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_exp(input logic [W-1:0] g, input logic [W-1:0] r,
                           input logic [W-1:0] f, input logic [W-1:0] st);
        e_gpi = g; e_rise = r; e_fall = f; e_st = st;
    endtask

    // Wait one edge and record the expected post-edge state. The task
    // returns just after the negedge, so the next inputs are driven well
    // away from the rising edge.
    task automatic tick(input string n);
        @(posedge PCLK);
        #1;
        push_exp(n);
        @(negedge PCLK);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        PRESET = 1'b0; pad_in = 8'hFF; db_en = 8'h00;
        evt_clr = 8'h00; irq_mask = 8'h00;
        set_exp(8'h00, 8'h00, 8'h00, 8'h00);

        // Reset and bypass
        repeat (3) tick("reset_hold");
        PRESET = 1'b1;
        tick("rel_e1");
        tick("rel_e2");
        set_exp(8'hFF, 8'hFF, 8'h00, 8'hFF); tick("rel_e3");
        set_exp(8'hFF, 8'h00, 8'h00, 8'hFF); tick("rel_e4"); tick("rel_e5");
        evt_clr = 8'hFF;
        set_exp(8'hFF, 8'h00, 8'h00, 8'h00); tick("clr_all");
        evt_clr = 8'h00;
        pad_in = 8'h00;
        tick("byp_fall_e1"); tick("byp_fall_e2");
        set_exp(8'h00, 8'h00, 8'hFF, 8'hFF); tick("byp_fall_e3");
        set_exp(8'h00, 8'h00, 8'h00, 8'hFF); tick("byp_fall_e4");
        evt_clr = 8'hFF;
        set_exp(8'h00, 8'h00, 8'h00, 8'h00); tick("clr_all2");
        evt_clr = 8'h00;

        // Bounce rejection: 3 cycles high is one short of acceptance
        db_en = 8'h01; pad_in = 8'h01;
        repeat (3) tick("bounce_hi");
        pad_in = 8'h00;
        repeat (5) tick("bounce_lo");

        // Debounced accept, then debounced fall with a coincident clear
        pad_in = 8'h01;
        repeat (5) tick("db_rise_wait");
        set_exp(8'h01, 8'h01, 8'h00, 8'h01); tick("db_rise_e6");
        set_exp(8'h01, 8'h00, 8'h00, 8'h01);
        repeat (4) tick("db_rise_hold");
        pad_in = 8'h00;
        repeat (5) tick("db_fall_wait");
        evt_clr = 8'h01;
        set_exp(8'h00, 8'h00, 8'h01, 8'h01); tick("set_beats_clr");
        set_exp(8'h00, 8'h00, 8'h00, 8'h00); tick("clr_no_evt");
        evt_clr = 8'h00;

        // Masking
        db_en = 8'h00; pad_in = 8'h04;
        tick("mask_e1"); tick("mask_e2");
        set_exp(8'h04, 8'h04, 8'h00, 8'h04); tick("mask_e3");
        set_exp(8'h04, 8'h00, 8'h00, 8'h04); tick("mask_off");
        irq_mask = 8'h04;
        #1;
        check("irq_same_cycle", 32'(irq), 32'(model_irq()));
        tick("mask_on");
        evt_clr = 8'h04;
        set_exp(8'h04, 8'h00, 8'h00, 8'h00); tick("mask_clr");
        evt_clr = 8'h00;

        // Mid-count switch from debounce to bypass
        irq_mask = 8'h06; db_en = 8'h02; pad_in = 8'h06;
        repeat (4) tick("mid_cnt");
        check("cnt1_after_2", 32'(dut.cnt_q[1]), 32'd2);
        db_en = 8'h00;
        set_exp(8'h06, 8'h02, 8'h00, 8'h02); tick("mid_byp");
        check("cnt1_zero", 32'(dut.cnt_q[1]), 32'd0);
        set_exp(8'h06, 8'h00, 8'h00, 8'h02); tick("mid_byp_hold");

        // Reset asserted mid-count
        db_en = 8'h01; pad_in = 8'h07;
        repeat (4) tick("rst_mid_cnt");
        check("cnt0_before_rst", 32'(dut.cnt_q[0]), 32'd2);
        PRESET = 1'b0;
        #1;
        check("rst_async_gpi",    32'(gpi),        32'd0);
        check("rst_async_status", 32'(evt_status), 32'd0);
        check("rst_async_irq",    32'(irq),        32'd0);
        check("rst_async_cnt0",   32'(dut.cnt_q[0]), 32'd0);
        set_exp(8'h00, 8'h00, 8'h00, 8'h00);
        repeat (2) tick("rst_hold2");
        PRESET = 1'b1;
        tick("rel2_e1"); tick("rel2_e2");
        set_exp(8'h06, 8'h06, 8'h00, 8'h06); tick("rel2_e3");
        set_exp(8'h06, 8'h00, 8'h00, 8'h06); tick("rel2_e4"); tick("rel2_e5");
        set_exp(8'h07, 8'h01, 8'h00, 8'h07); tick("rel2_e6");
        set_exp(8'h07, 8'h00, 8'h00, 8'h07); tick("rel2_e7");

        // ---------------- final report ----------------
        @(negedge PCLK);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gpi_input_conditioner.md
# gpi_input_conditioner

Per-pin input conditioner that sits directly upstream of the GPI peripheral: it takes raw, asynchronous external pad levels and drives the clean `gpi` vector that the GPI block samples. Each bit is synchronized into the PCLK domain and optionally debounced. Optionally, the block also detects rising and falling edges, keeps sticky per-pin event status, and raises a maskable interrupt.

## Interface
- `WIDTH`, default 8: number of input pins.
- `SYNC_STAGES`, default 2, legal range ≥2: flip-flop synchronizer depth.
- `DB_CYCLES`, default 16, legal range ≥1: consecutive stable cycles needed to accept a new level. A value of 1 behaves like bypass.

Ports:
- `PCLK` in 1: single clock. All state is on its rising edge.
- `PRESET` in 1: asynchronous reset, active-low.
- `pad_in` in WIDTH: raw external pin levels, asynchronous to PCLK.
- `db_en` in WIDTH: per-bit debounce enable (1 = debounce, 0 = bypass).
- `gpi` out WIDTH: conditioned levels, fed to the GPI peripheral's `gpi` input.
- `rise_evt` out WIDTH: one-cycle pulse per bit on an accepted 0→1 transition of `gpi`.
- `fall_evt` out WIDTH: one-cycle pulse per bit on an accepted 1→0 transition of `gpi`.
- `evt_status` out WIDTH: sticky per-bit event flags.
- `evt_clr` in WIDTH: per-bit clear for `evt_status`, active-high, sampled each cycle.
- `irq_mask` in WIDTH: per-bit interrupt enable.
- `irq` out 1: OR of `evt_status & irq_mask`.

## Operation
**Synchronizer**
- `pad_in` passes through a `SYNC_STAGES`-deep flip-flop chain per bit.
- `s[i]` is the last stage of that chain.

**Debounce path** (`db_en[i]`=1). Each bit has its own counter `cnt[i]`, width $clog2(DB_CYCLES)+1. On each edge:
- If `s[i]` equals `gpi[i]`, then `cnt[i]` ← 0.
- Otherwise, if `cnt[i]` == DB_CYCLES−1, then `gpi[i]` ← `s[i]` and `cnt[i]` ← 0.
- Otherwise, `cnt[i]` ← `cnt[i]`+1.
- Any glitch that returns to the current `gpi[i]` level before the count completes restarts the count from 0.

**Bypass path** (`db_en[i]`=0)
- `gpi[i]` ← `s[i]` every edge.
- `cnt[i]` is held at 0.
- Changing `db_en[i]` mid-count takes effect on the next edge, with no partial-count carry-over.

**Edge detect**
- `rise_evt[i]` and `fall_evt[i]` are registered together with `gpi[i]`.
- Each is high for exactly the first cycle in which `gpi[i]` shows its new level.

**Status**
- On each edge, `evt_status[i]` ← (`evt_status[i]` & ~`evt_clr[i]`) | `rise_evt_next[i]` | `fall_evt_next[i]`.
- If a new event and a clear occur in the same cycle, the set wins.

**Interrupt**
- `irq` is combinational from `evt_status` and `irq_mask`.
- It is level-type and stays high until the relevant status bits are cleared or masked.

## Timing
- Reset (`PRESET`=0, asynchronous):
  - Synchronizer flops, `gpi`, `cnt`, `rise_evt`, `fall_evt` and `evt_status` all go to 0.
  - `irq` goes to 0.
- Reset asserted mid-count discards the count.
- A pad held high through reset release produces a `rise_evt` once the normal latency has elapsed.
- Latency from a `pad_in` change to `gpi`:
  - Bypass: SYNC_STAGES+1 edges.
  - Debounce: SYNC_STAGES+DB_CYCLES edges.
  - Both assume the pad is stable throughout.
- `rise_evt`/`fall_evt` are coincident with the `gpi` change.
- `evt_status` updates on the same edge.
- `irq` follows `evt_status` in the same cycle.
- Bits are fully independent. Simultaneous events on several bits all register on the same edge.
- The counter never wraps: it is reset at DB_CYCLES−1.

## Configuration
- `GPI_COND_EDGE_IRQ_EN` defined:
  - Edge detection, sticky `evt_status`, `evt_clr` handling and `irq` are built as described above.
- `GPI_COND_EDGE_IRQ_EN` undefined:
  - `rise_evt`, `fall_evt`, `evt_status` and `irq` are tied to 0.
  - `evt_clr` and `irq_mask` are ignored.
  - No event logic is synthesized.
  - Ports remain present and the synchronizer and debounce behaviour is unchanged.

## Test plan
All scenarios use WIDTH=8, SYNC_STAGES=2, DB_CYCLES=4, with the macro defined.
- Reset and bypass: hold `PRESET`=0 with `pad_in`=0xFF → `gpi`=0x00, `evt_status`=0x00, `irq`=0. Release with `db_en`=0x00 → `gpi`=0xFF on the 3rd edge, `rise_evt`=0xFF for exactly one cycle, `evt_status`=0xFF.
- Bounce rejection: `db_en`=0x01, `pad_in[0]` high for 3 cycles then low → `gpi[0]` stays 0, no `rise_evt[0]`, `evt_status[0]`=0.
- Debounced accept: `pad_in[0]` 0→1 held for 10 cycles → `gpi[0]` rises exactly 6 edges after the change and `rise_evt[0]` pulses once. Then 1→0 held → `fall_evt[0]` pulses 6 edges later.
- Set beats clear: `evt_status[0]`=1 and `evt_clr`=0x01 on the same edge as a new `fall_evt[0]` → `evt_status[0]` remains 1. Next cycle, `evt_clr`=0x01 with no event → `evt_status[0]`=0.
- Masking: `evt_status`=0x04 with `irq_mask`=0x00 → `irq`=0. Set `irq_mask`=0x04 → `irq`=1 in the same cycle. Clear bit 2 → `irq`=0.
- Mid-count change: `db_en[1]` drops from 1 to 0 after 2 stable cycles of a new level → `gpi[1]` takes the new level on the next edge and `cnt[1]`=0. Asserting reset mid-count clears all outputs immediately.
